dmac_peri_desc_slave: RTL and testbench

//  Peripheral-side AHB-Lite responder for the DMAC configuration fetch. Holds one 4-word transfer

---
 rtl/dmac_pkg.sv | 45 ++++
 rtl/dmac_desc_regfile.sv | 44 ++++
 rtl/dmac_peri_desc_slave.sv | 141 ++++++++++++++
 tb/tb_dmac_peri_desc_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMAC peripheral-side descriptor slave.
// The AHB transfer-type encoding is also used by the DMAC itself.
package dmac_pkg;

    typedef enum logic [1:0] {
        HT_IDLE    = 2'b00,
        HT_BUSY    = 2'b01,
        HT_NON_SEQ = 2'b10,
        HT_SEQ     = 2'b11
    } HTrans_t;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } resp_t;

    typedef enum logic [2:0] {
        B_IDLE,
        B_WAIT,
        B_LAST,
        B_ERR1,
        B_ERR2
    } bus_state_t;

    // Encoded so that bit 1 is busy and bit 0 is the request line.
    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_SERV = 2'b10,
        R_PEND = 2'b11
    } req_state_t;

    localparam logic [3:0] SRC_OFS  = 4'h0;
    localparam logic [3:0] DST_OFS  = 4'h4;
    localparam logic [3:0] SIZE_OFS = 4'h8;
    localparam logic [3:0] CTRL_OFS = 4'hC;

    localparam logic [1:0] SIZE_IDX   = 2'd2;
    localparam logic [1:0] CTRL_IDX   = 2'd3;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    function automatic logic [1:0] ofs_to_idx(input logic [3:0] ofs);
        return ofs[3:2];
    endfunction

endpackage

// File: rtl/dmac_desc_regfile.sv
// Four-word transfer descriptor. The bus port overrides the local port on the
// same register; rd_next returns the value a register holds after this edge.
module dmac_desc_regfile
    import dmac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic [1:0]  bus_idx,
    input  logic [31:0] bus_wdata,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_idx,
    input  logic [31:0] cfg_wdata,
    input  logic [1:0]  rd_idx,
    output logic [31:0] rd_next,
    output logic        ctrl_repeat
);

    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
            if (cfg_we && cfg_idx == 2'(i)) regs_d[i] = cfg_wdata;
            if (bus_we && bus_idx == 2'(i)) regs_d[i] = bus_wdata;
        end
        // Only the low half of SIZE is implemented.
        regs_d[SIZE_IDX][31:16] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Reading the next value lets a read directly behind a write see the new data.
    assign rd_next     = regs_d[rd_idx];
    assign ctrl_repeat = regs_q[CTRL_IDX][0];

endmodule

// File: rtl/dmac_peri_desc_slave.sv
// AHB-Lite responder serving the DMAC descriptor fetch, plus the DMA request
// handshake (arm -> request -> ack -> service -> done).
module dmac_peri_desc_slave
    import dmac_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1,
    parameter bit AUTO_REARM  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSel,
    input  logic [ADDR_W-1:0] HAddr,
    input  logic [1:0]        HTrans,
    input  logic              HWrite,
    input  logic [2:0]        HSize,
    input  logic [31:0]       HWData,
    input  logic              HReady,
    output logic [31:0]       HRData,
    output logic              HReadyOut,
    output logic              HResp,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_idx,
    input  logic [31:0]       cfg_wdata,
    input  logic              arm,
    input  logic              ReqAck,
    input  logic              xfer_done,
    output logic              DmacReq,
    output logic              busy
);

    localparam logic [2:0]        WS_LOAD  = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
    localparam logic [ADDR_W-1:0] IDX_BITS = ADDR_W'(12);

    bus_state_t bus_q, bus_d;
    req_state_t req_q, req_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  lat_idx;
    logic        lat_write;
    logic [31:0] hrdata_q;
    logic        hready_out;
    logic        accept;
    logic        bad;
    logic [1:0]  addr_idx;
    logic [1:0]  rd_idx;
    logic        rd_is_read;
    logic        bus_we;
    logic [31:0] rd_next;
    logic        ctrl_repeat;

    assign hready_out = (bus_q == B_IDLE) || (bus_q == B_LAST) || (bus_q == B_ERR2);
    assign accept     = HSel && HReady && hready_out &&
                        (HTrans == HT_NON_SEQ || HTrans == HT_SEQ);
    assign addr_idx   = ofs_to_idx(HAddr[3:0]);
    assign bad        = (HSize != HSIZE_WORD) || (|(HAddr & ~IDX_BITS)) || (HWrite && busy);

    always_comb begin
        bus_d = bus_q;
        cnt_d = cnt_q;
        case (bus_q)
            B_WAIT: begin
                if (cnt_q == 3'd0) bus_d = B_LAST;
                else               cnt_d = cnt_q - 3'd1;
            end
            B_ERR1: bus_d = B_ERR2;
            default: begin
                bus_d = B_IDLE;
                if (accept) begin
                    if (bad) begin
                        bus_d = B_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        bus_d = B_LAST;
                    end else begin
                        bus_d = B_WAIT;
                        cnt_d = WS_LOAD;
                    end
                end
            end
        endcase
    end

    // The transfer entering completion is either the stalled one or, with no
    // wait states, the one being accepted right now.
    assign rd_idx     = (bus_q == B_WAIT) ? lat_idx : addr_idx;
    assign rd_is_read = (bus_q == B_WAIT) ? !lat_write : !HWrite;
    assign bus_we     = (bus_q == B_LAST) && lat_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q     <= B_IDLE;
            cnt_q     <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            hrdata_q  <= '0;
        end else begin
            bus_q <= bus_d;
            cnt_q <= cnt_d;
            if (accept) begin
                lat_idx   <= addr_idx;
                lat_write <= HWrite;
            end
            if (bus_d == B_LAST && rd_is_read) hrdata_q <= rd_next;
        end
    end

    always_comb begin
        req_d = req_q;
        case (req_q)
            R_IDLE:  if (arm)       req_d = R_PEND;
            R_PEND:  if (ReqAck)    req_d = R_SERV;
            R_SERV:  if (xfer_done) req_d = (AUTO_REARM && ctrl_repeat) ? R_PEND : R_IDLE;
            default: req_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_q <= R_IDLE;
        else     req_q <= req_d;
    end

    dmac_desc_regfile u_regs (
        .clk         (clk),
        .rst         (rst),
        .bus_we      (bus_we),
        .bus_idx     (lat_idx),
        .bus_wdata   (HWData),
        .cfg_we      (cfg_we && !busy),
        .cfg_idx     (cfg_idx),
        .cfg_wdata   (cfg_wdata),
        .rd_idx      (rd_idx),
        .rd_next     (rd_next),
        .ctrl_repeat (ctrl_repeat)
    );

    assign HRData    = hrdata_q;
    assign HReadyOut = hready_out;
    assign HResp     = (bus_q == B_ERR1 || bus_q == B_ERR2) ? RESP_ERROR : RESP_OKAY;
    assign DmacReq   = (req_q == R_PEND);
    assign busy      = (req_q != R_IDLE);

endmodule

// File: tb/tb_dmac_peri_desc_slave.sv
// Two instances (one wait state with auto re-arm, zero wait states without)
// share stimulus and are checked every cycle against a transaction-level model.
module tb_dmac_peri_desc_slave;
    import dmac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        HSel, HWrite, cfg_we, arm, ReqAck, xfer_done;
    logic [11:0] HAddr;
    logic [1:0]  HTrans, cfg_idx;
    logic [2:0]  HSize;
    logic [31:0] HWData, cfg_wdata;

    logic [31:0] rdata1, rdata0;
    logic        ready1, ready0, resp1, resp0, req1, req0, busy1, busy0;

    dmac_peri_desc_slave #(.ADDR_W(12), .WAIT_STATES(1), .AUTO_REARM(1'b1)) u_ws1 (
        .clk(clk), .rst(rst), .HSel(HSel), .HAddr(HAddr), .HTrans(HTrans), .HWrite(HWrite),
        .HSize(HSize), .HWData(HWData), .HReady(ready1), .HRData(rdata1), .HReadyOut(ready1),
        .HResp(resp1), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .arm(arm),
        .ReqAck(ReqAck), .xfer_done(xfer_done), .DmacReq(req1), .busy(busy1));

    dmac_peri_desc_slave #(.ADDR_W(12), .WAIT_STATES(0), .AUTO_REARM(1'b0)) u_ws0 (
        .clk(clk), .rst(rst), .HSel(HSel), .HAddr(HAddr), .HTrans(HTrans), .HWrite(HWrite),
        .HSize(HSize), .HWData(HWData), .HReady(ready0), .HRData(rdata0), .HReadyOut(ready0),
        .HResp(resp0), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .arm(arm),
        .ReqAck(ReqAck), .xfer_done(xfer_done), .DmacReq(req0), .busy(busy0));

    // One outstanding data phase: ph_left counts remaining stalled cycles.
    typedef struct packed {
        logic [3:0][31:0] regs;
        logic [31:0]      hrdata;
        logic             ph_valid;
        logic             ph_err;
        logic             ph_write;
        logic [1:0]       ph_idx;
        logic [3:0]       ph_left;
        logic             pend;
        logic             serv;
    } mdl_t;

    mdl_t m1, m0;
    int errors = 0;
    int checks = 0;

    function automatic mdl_t mdl_step(input mdl_t m, input int ws, input bit rearm);
        mdl_t n        = m;
        bit   busy_old = m.pend | m.serv;
        bit   ctrl0    = m.regs[3][0];
        bit   ready    = !m.ph_valid || m.ph_left == 0;
        bit   entered  = 1'b0;
        bit   err;
        if (cfg_we && !busy_old)
            n.regs[cfg_idx] = (cfg_idx == 2'd2) ? {16'h0, cfg_wdata[15:0]} : cfg_wdata;
        if (m.ph_valid && !m.ph_err && m.ph_left == 0 && m.ph_write)
            n.regs[m.ph_idx] = (m.ph_idx == 2'd2) ? {16'h0, HWData[15:0]} : HWData;
        if (m.ph_valid && m.ph_left != 0) begin
            n.ph_left = m.ph_left - 4'd1;
            entered   = (n.ph_left == 0) && !m.ph_err;
        end else if (ready && HSel && (HTrans == 2'd2 || HTrans == 2'd3)) begin
            err        = (HSize != 3'd2) || ((HAddr & ~12'h00C) != 0) || (HWrite && busy_old);
            n.ph_valid = 1'b1;
            n.ph_err   = err;
            n.ph_write = HWrite;
            n.ph_idx   = HAddr[3:2];
            n.ph_left  = err ? 4'd1 : 4'(ws);
            entered    = !err && ws == 0;
        end else begin
            n.ph_valid = 1'b0;
        end
        if (entered && !n.ph_write) n.hrdata = n.regs[n.ph_idx];
        if (!m.pend && !m.serv) begin
            if (arm) n.pend = 1'b1;
        end else if (m.pend) begin
            if (ReqAck) begin n.pend = 1'b0; n.serv = 1'b1; end
        end else if (xfer_done) begin
            n.serv = 1'b0;
            n.pend = rearm && ctrl0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= '0;
            m0 <= '0;
        end else begin
            m1 <= mdl_step(m1, 1, 1'b1);
            m0 <= mdl_step(m0, 0, 1'b0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("ws1_ready", ready1, 32'(!m1.ph_valid || m1.ph_left == 0));
            check("ws1_resp",  resp1,  32'(m1.ph_valid && m1.ph_err));
            check("ws1_rdata", rdata1, m1.hrdata);
            check("ws1_req",   req1,   32'(m1.pend));
            check("ws1_busy",  busy1,  32'(m1.pend | m1.serv));
            check("ws0_ready", ready0, 32'(!m0.ph_valid || m0.ph_left == 0));
            check("ws0_resp",  resp0,  32'(m0.ph_valid && m0.ph_err));
            check("ws0_rdata", rdata0, m0.hrdata);
            check("ws0_req",   req0,   32'(m0.pend));
            check("ws0_busy",  busy0,  32'(m0.pend | m0.serv));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_idle();
        HSel = 1'b0; HTrans = HT_IDLE; HWrite = 1'b0; HSize = 3'd2; HAddr = '0;
    endtask

    task automatic bus_set(input logic wr, input logic [11:0] a, input logic [2:0] sz);
        HSel = 1'b1; HTrans = HT_NON_SEQ; HWrite = wr; HAddr = a; HSize = sz;
    endtask

    logic [31:0] vals [4];
    logic [11:0] bad_addr [2];
    logic [2:0]  bad_size [2];

    initial begin
        vals[0] = 32'h1000; vals[1] = 32'h2000; vals[2] = 32'h10; vals[3] = 32'h1;
        bad_addr[0] = 12'h010; bad_size[0] = 3'd2;
        bad_addr[1] = 12'h000; bad_size[1] = 3'd0;
        bus_idle();
        HWData = '0; cfg_we = 0; cfg_idx = 0; cfg_wdata = 0; arm = 0; ReqAck = 0; xfer_done = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("reset_ready", ready1, 1);
        check("reset_req", req1, 0);
        step();

        for (int i = 0; i < 4; i++) begin
            cfg_we = 1; cfg_idx = 2'(i); cfg_wdata = vals[i];
            step();
        end
        cfg_we = 0;
        arm = 1; step(); arm = 0;
        check("t1_req_rise", req1, 1);
        ReqAck = 1; step(); ReqAck = 0;
        check("t1_req_fall", req1, 0);
        check("t1_busy_serv", busy1, 1);
        for (int i = 0; i < 4; i++) begin
            bus_set(1'b0, 12'(i * 4), 3'd2);
            step();
            check("t1_stall", ready1, 0);
            step();
            check("t1_done_ready", ready1, 1);
            check("t1_rdata", rdata1, vals[i]);
            check("t1_resp", resp1, 0);
        end

        for (int k = 0; k < 2; k++) begin
            bus_set(1'b0, bad_addr[k], bad_size[k]);
            step();
            check("t2_err1_ready", ready1, 0);
            check("t2_err1_resp", resp1, 1);
            bus_idle();
            step();
            check("t2_err2_ready", ready1, 1);
            check("t2_err2_resp", resp1, 1);
            step();
            check("t2_after_resp", resp1, 0);
        end

        xfer_done = 1; step(); xfer_done = 0;
        check("t4_rearm", req1, 1);
        check("t4_norearm_ws0_req", req0, 0);
        check("t4_norearm_ws0_busy", busy0, 0);

        bus_set(1'b1, 12'h004, 3'd2); HWData = 32'h55;
        step();
        check("t3_busy_wr_err", resp1, 1);
        bus_set(1'b0, 12'h004, 3'd2);
        step();
        check("t3_busy_wr_err2", resp1, 1);
        step();
        step();
        check("t3_dst_kept", rdata1, 32'h2000);
        bus_idle();
        step();

        bus_set(1'b0, 12'h000, 3'd2);
        step();
        check("t6_pre_stall", ready1, 0);
        check("t6_pre_req", req1, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_ready", ready1, 1);
        check("t6_req", req1, 0);
        check("t6_busy", busy1, 0);
        check("t6_rdata", rdata1, 0);
        bus_idle();
        step(); step();
        rst = 1'b0;

        bus_set(1'b0, 12'h008, 3'd2); HWData = 32'h0;
        step(); step();
        check("t6_size_zero", rdata1, 0);
        bus_set(1'b1, 12'h004, 3'd2); HWData = 32'hAA;
        step();
        bus_idle();
        step();
        cfg_we = 1; cfg_idx = 2'd1; cfg_wdata = 32'hBB;
        step();
        cfg_we = 0;
        bus_set(1'b0, 12'h004, 3'd2);
        step(); step();
        check("t3_bus_wins", rdata1, 32'hAA);
        bus_idle();

        cfg_we = 1; cfg_idx = 2'd3; cfg_wdata = 32'h0; step(); cfg_we = 0;
        arm = 1; step(); arm = 0;
        ReqAck = 1; step(); ReqAck = 0;
        xfer_done = 1; step(); xfer_done = 0;
        check("t4_ctrl0_req", req1, 0);
        check("t4_ctrl0_busy", busy1, 0);

        HSel = 1; HTrans = HT_BUSY; HAddr = 12'h3F1;
        step();
        check("t5_busy_trans", ready1, 1);
        HSel = 0; HTrans = HT_NON_SEQ;
        step();
        check("t5_unsel_resp", resp1, 0);
        check("t5_unsel_ready", ready1, 1);

        for (int n = 0; n < 4000; n++) begin
            HSel      = ($urandom_range(0, 7) != 0);
            HTrans    = 2'($urandom_range(0, 3));
            HWrite    = ($urandom_range(0, 2) == 0);
            HAddr     = ($urandom_range(0, 11) != 0) ? {8'h0, 2'($urandom_range(0, 3)), 2'b00}
                                                     : 12'($urandom);
            HSize     = ($urandom_range(0, 9) != 0) ? 3'd2 : 3'($urandom_range(0, 7));
            HWData    = $urandom;
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_idx   = 2'($urandom_range(0, 3));
            cfg_wdata = $urandom;
            arm       = ($urandom_range(0, 7) == 0);
            ReqAck    = ($urandom_range(0, 5) == 0);
            xfer_done = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
